edge_event_arbiter: RTL

//  Multi-channel rising-edge event scheduler. Each of N level inputs has its own

---
 rtl/edge_event_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel rising-edge detectors feed a pending-bit
// queue. A round-robin arbiter drains the queue one channel ID per accepted
// transfer on a single valid/ready event port.
module edge_event_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    level,
    output logic            evt_valid,
    output logic [ID_W-1:0] evt_id,
    input  logic            evt_ready,
    output logic [N-1:0]    pending,
    output logic [N-1:0]    overflow,
    input  logic [N-1:0]    ovf_clr
);

    typedef enum logic {S_IDLE, S_PRESENT} state_t;

    state_t            r_state;
    logic [N-1:0]      r_lvl_q;
    logic [N-1:0]      r_pending;
    logic [N-1:0]      r_overflow;
    logic              r_evt_valid;
    logic [ID_W-1:0]   r_evt_id;
    logic [ID_W-1:0]   r_ptr;

    logic [N-1:0]      w_rise;
    logic [2*N-1:0]    w_rot;
    logic              w_found;
    logic [ID_W-1:0]   w_winner;
    logic [ID_W:0]     w_sum;
    logic              w_grant;
    logic [N-1:0]      w_gmask;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [N-1:0]      w_pend_nxt;
    logic [N-1:0]      w_ovf_nxt;

    // Rising edge against last cycle's sampled level (lvl_q resets to 0, so
    // a level held high through reset still produces one event).
    assign w_rise = level & ~r_lvl_q;

    // Rotate the pending vector so bit 0 is the channel at the RR pointer;
    // the first set bit found is then the offset of the winner from ptr.
    assign w_rot = {r_pending, r_pending} >> r_ptr;

    // Priority-encode the rotated vector and map the offset back to a channel.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int j = 0; j < N; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (ID_W+1)'(j);
                if (w_sum >= (ID_W+1)'(N))
                    w_sum = w_sum - (ID_W+1)'(N);
                w_winner = w_sum[ID_W-1:0];
            end
        end
    end

    // A grant loads the port: from IDLE whenever something is queued, or
    // back-to-back from PRESENT when the current event is being accepted.
    assign w_grant   = w_found && ((r_state == S_IDLE) || evt_ready);
    assign w_gmask   = w_grant ? ({{(N-1){1'b0}}, 1'b1} << w_winner) : '0;
    assign w_ptr_nxt = (w_winner == ID_W'(N-1)) ? '0 : w_winner + 1'b1;

    // A new edge on the channel being granted re-queues it (set wins over
    // clear); an edge on a still-queued channel is lost and flagged. A new
    // overflow also beats a same-cycle ovf_clr.
    assign w_pend_nxt = (r_pending & ~w_gmask) | w_rise;
    assign w_ovf_nxt  = (r_overflow & ~ovf_clr) | (w_rise & r_pending & ~w_gmask);

    // Edge sampling, queue state and the IDLE/PRESENT event-port FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lvl_q     <= '0;
            r_pending   <= '0;
            r_overflow  <= '0;
            r_evt_valid <= 1'b0;
            r_evt_id    <= '0;
            r_ptr       <= '0;
        end else begin
            r_lvl_q    <= level;
            r_pending  <= w_pend_nxt;
            r_overflow <= w_ovf_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_evt_valid <= 1'b1;
                        r_evt_id    <= w_winner;
                        r_ptr       <= w_ptr_nxt;
                        r_state     <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (evt_ready) begin
                        if (w_grant) begin
                            r_evt_id <= w_winner;
                            r_ptr    <= w_ptr_nxt;
                        end else begin
                            r_evt_valid <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_evt_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule
